// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit with req/gnt/rvalid port, stall and misalignment detection
module mem_access_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    MemReadM,
  input  logic                    MemWriteM,
  input  logic [2:0]              Funct3M,
  input  logic [DATA_WIDTH-1:0]   ALUResultM,
  input  logic [DATA_WIDTH-1:0]   WriteDataM,
  output logic                    Stall,
  output logic [DATA_WIDTH-1:0]   ReadDataM,
  output logic                    MisalignedM,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [3:0]              mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            f3_q, f3_d;
  logic                  is_store, is_load, legal, aligned, in_idle, valid;
  logic [1:0]            sz, off;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic [DATA_WIDTH-1:0] ld_ext;
  always_comb begin
    is_store = MemWriteM;
    is_load  = MemReadM & ~MemWriteM;
    sz       = Funct3M[1:0];
    // stores only accept the signed encodings; loads also accept LBU/LHU
    legal    = is_store ? (~Funct3M[2] & (sz != 2'b11)) :
               is_load  ? ((sz != 2'b11) & ~(Funct3M[2] & Funct3M[1])) : 1'b0;
    aligned  = (sz == 2'b10) ? (ALUResultM[1:0] == 2'b00) :
               (sz == 2'b01) ? ~ALUResultM[0] : 1'b1;
    in_idle  = state_q == IDLE;
    valid    = in_idle & legal & aligned;
    MisalignedM = in_idle & legal & ~aligned;
    Stall    = valid | (state_q == REQ) | (state_q == WAIT);
  end
  always_comb begin
    off    = addr_q[1:0];
    ld_b   = (off == 2'd0) ? mem_rdata[7:0]   :
             (off == 2'd1) ? mem_rdata[15:8]  :
             (off == 2'd2) ? mem_rdata[23:16] : mem_rdata[31:24];
    ld_h   = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_ext = (f3_q == 3'b000) ? {{24{ld_b[7]}}, ld_b}  :
             (f3_q == 3'b001) ? {{16{ld_h[15]}}, ld_h} :
             (f3_q == 3'b100) ? {24'd0, ld_b}          :
             (f3_q == 3'b101) ? {16'd0, ld_h}          : mem_rdata;
  end
  always_comb begin
    state_d = in_idle          ? (valid ? REQ : IDLE) :
              (state_q == REQ)  ? (mem_gnt ? (we_q ? DONE : WAIT) : REQ) :
              (state_q == WAIT) ? (mem_rvalid ? DONE : WAIT) : IDLE;
    addr_d  = valid ? ALUResultM : addr_q;
    we_d    = valid ? is_store : we_q;
    f3_d    = valid ? Funct3M : f3_q;
    be_d    = ~valid ? be_q :
              (~is_store | (sz == 2'b10)) ? 4'b1111 :
              (sz == 2'b01) ? (ALUResultM[1] ? 4'b1100 : 4'b0011) :
              4'b0001 << ALUResultM[1:0];
    wdata_d = ~valid ? wdata_q :
              (sz == 2'b00) ? {4{WriteDataM[7:0]}}  :
              (sz == 2'b01) ? {2{WriteDataM[15:0]}} : WriteDataM;
    rdata_d = ((state_q == WAIT) & mem_rvalid) ? ld_ext : rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      f3_q    <= 3'b000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_req   = state_q == REQ;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;
  assign ReadDataM = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: table-driven directed checks of the load/store unit plus wait-state and reset sequences
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = '0, WriteDataM = '0;
  logic        Stall, MisalignedM, mem_req, mem_we;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  int total = 0, bad = 0;
  logic [31:0] cur_rd = '0;

  mem_access_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .Stall(Stall), .ReadDataM(ReadDataM), .MisalignedM(MisalignedM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    int mode;
    int stalls;
    logic [3:0] be;
    logic [31:0] maddr, mwd, rdv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rd, wr, input logic [2:0] f3, input logic [31:0] addr, wd,
                              input int mode, stalls, input logic [3:0] be,
                              input logic [31:0] maddr, mwd, rdv);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.mode = mode;
    v.stalls = stalls; v.be = be; v.maddr = maddr; v.mwd = mwd; v.rdv = rdv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000; ALUResultM = '0; WriteDataM = '0;
  endtask

  // mode 0 access, 1 misaligned, 2 no-op; gnt after gd ungranted REQ cycles, rvalid rdly cycles after gnt
  task automatic run(input string nm, input vec_t v, input int gd, rdly, input bit spur, input logic [31:0] good);
    int stalls = 0, reqc = 0, gcyc = -1;
    bit done = 0;
    MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3; ALUResultM = v.addr; WriteDataM = v.wd;
    mem_rdata = good;
    #1;
    chk({nm, " mis"}, {31'd0, MisalignedM}, {31'd0, v.mode == 1});
    for (int cyc = 0; cyc < 40; cyc++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = good;
      if (gcyc < 0 && spur) begin
        mem_rvalid = 1'b1; mem_rdata = ~good;
      end else if (gcyc >= 0 && cyc == gcyc + rdly && !v.wr) mem_rvalid = 1'b1;
      if (mem_req) begin
        chk({nm, " addr"}, mem_addr, v.maddr);
        chk({nm, " be"}, {28'd0, mem_be}, {28'd0, v.be});
        chk({nm, " we"}, {31'd0, mem_we}, {31'd0, v.wr});
        if (v.wr) chk({nm, " wdata"}, mem_wdata, v.mwd);
        if (reqc == gd) begin
          mem_gnt = 1'b1; gcyc = cyc;
        end
        reqc++;
      end
      if (!Stall) begin
        done = 1;
        break;
      end
      stalls++;
      chk({nm, " rd_hold"}, ReadDataM, cur_rd);
      @(negedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout: Stall still high, want low within 40 cycles", nm);
    end
    chk({nm, " stalls"}, stalls, v.stalls);
    chk({nm, " rdata"}, ReadDataM, v.rdv);
    cur_rd = v.rdv;
    if (v.mode != 0) begin
      chk({nm, " req"}, {31'd0, mem_req}, 32'd0);
      @(negedge clk); #1;
      chk({nm, " mis2"}, {31'd0, MisalignedM}, {31'd0, v.mode == 1});
      chk({nm, " stall2"}, {31'd0, Stall}, 32'd0);
    end
    clear_in();
    @(negedge clk); #1;
    chk({nm, " idle_req"}, {31'd0, mem_req}, 32'd0);
    chk({nm, " idle_rd"}, ReadDataM, cur_rd);
  endtask

  initial begin
    vq.push_back(mk(0,1,3'b010,32'h1006,32'hDEADBEEF,1,0,4'h0,0,0,32'h0));
    vq.push_back(mk(0,1,3'b010,32'h1004,32'hDEADBEEF,0,2,4'hF,32'h1004,32'hDEADBEEF,32'h0));
    vq.push_back(mk(0,1,3'b000,32'h1003,32'h000000A5,0,2,4'h8,32'h1000,32'hA5A5A5A5,32'h0));
    vq.push_back(mk(0,1,3'b001,32'h1002,32'h00001234,0,2,4'hC,32'h1000,32'h12341234,32'h0));
    vq.push_back(mk(0,1,3'b000,32'h1001,32'h0000005A,0,2,4'h2,32'h1000,32'h5A5A5A5A,32'h0));
    vq.push_back(mk(0,1,3'b001,32'h1000,32'hABCD5678,0,2,4'h3,32'h1000,32'h56785678,32'h0));
    vq.push_back(mk(1,0,3'b000,32'h2003,32'h0,0,3,4'hF,32'h2000,0,32'hFFFFFF80));
    vq.push_back(mk(1,0,3'b100,32'h2003,32'h0,0,3,4'hF,32'h2000,0,32'h00000080));
    vq.push_back(mk(1,0,3'b000,32'h2001,32'h0,0,3,4'hF,32'h2000,0,32'h0000007F));
    vq.push_back(mk(1,0,3'b001,32'h2000,32'h0,0,3,4'hF,32'h2000,0,32'h00007F01));
    vq.push_back(mk(1,0,3'b101,32'h2002,32'h0,0,3,4'hF,32'h2000,0,32'h000080FF));
    vq.push_back(mk(1,0,3'b001,32'h2002,32'h0,0,3,4'hF,32'h2000,0,32'hFFFF80FF));
    vq.push_back(mk(1,0,3'b010,32'h2000,32'h0,0,3,4'hF,32'h2000,0,32'h80FF7F01));
    vq.push_back(mk(1,0,3'b001,32'h2001,32'h0,1,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(0,1,3'b001,32'h1001,32'h1,1,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(1,0,3'b010,32'h2002,32'h0,1,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(1,0,3'b011,32'h2000,32'h0,2,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(0,1,3'b110,32'h1000,32'h0,2,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(0,0,3'b010,32'h2000,32'h0,2,0,4'h0,0,0,32'h80FF7F01));
    vq.push_back(mk(1,1,3'b010,32'h3000,32'h11223344,0,2,4'hF,32'h3000,32'h11223344,32'h80FF7F01));

    #1;
    chk("rst req", {31'd0, mem_req}, 32'd0);
    chk("rst we", {31'd0, mem_we}, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst be", {28'd0, mem_be}, 32'd0);
    chk("rst wdata", mem_wdata, 32'd0);
    chk("rst rdata", ReadDataM, 32'd0);
    chk("rst stall", {31'd0, Stall}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    foreach (vq[i]) run($sformatf("v%0d", i), vq[i], 0, 1, 1'b0, 32'h80FF7F01);

    run("wait", mk(1,0,3'b010,32'h2004,32'h0,0,7,4'hF,32'h2004,0,32'h13579BDF), 3, 2, 1'b0, 32'h13579BDF);
    run("spur", mk(1,0,3'b101,32'h2006,32'h0,0,4,4'hF,32'h2004,0,32'h0000C3A5), 1, 1, 1'b1, 32'hC3A50F0F);

    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk); #1;
    mem_rvalid = 1'b0;
    chk("idle_rvalid rd", ReadDataM, 32'h0000C3A5);
    chk("idle_rvalid stall", {31'd0, Stall}, 32'd0);

    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h2000; mem_rdata = 32'h55AA55AA;
    @(negedge clk); #1;
    mem_gnt = 1'b1;
    @(negedge clk); #1;
    mem_gnt = 1'b0;
    chk("rstw stall_pre", {31'd0, Stall}, 32'd1);
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("rstw req", {31'd0, mem_req}, 32'd0);
    chk("rstw rd", ReadDataM, 32'd0);
    chk("rstw stall", {31'd0, Stall}, 32'd0);
    chk("rstw addr", mem_addr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    mem_rvalid = 1'b1;
    @(negedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk); #1;
    chk("late_rvalid rd", ReadDataM, 32'd0);
    chk("late_rvalid req", {31'd0, mem_req}, 32'd0);

    MemWriteM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h4000; WriteDataM = 32'h01020304;
    @(negedge clk); #1;
    chk("rstq req_pre", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    clear_in();
    #1;
    chk("rstq req", {31'd0, mem_req}, 32'd0);
    chk("rstq we", {31'd0, mem_we}, 32'd0);
    chk("rstq wdata", mem_wdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rstq idle", {31'd0, Stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit that consumes the execute stage's ALUResult (as the effective address) and the forwarded RD2 (as store data). It drives a request/grant/response data-memory port and stalls the pipeline while an access is outstanding. It returns sign- or zero-extended load data, and flags misaligned accesses instead of issuing them. It sits between the execute outputs and the writeback result mux.

## Interface
- DATA_WIDTH, 32, data and address width; behaviour below is defined for 32 only.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- MemReadM  input  1  load in memory stage
- MemWriteM  input  1  store in memory stage; if both are high, treated as a store
- Funct3M  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other value is a no-op
- ALUResultM  input  32  effective byte address
- WriteDataM  input  32  store data, low bytes significant
- Stall  output  1  hold all earlier pipeline registers this cycle
- ReadDataM  output  32  extended load data, registered
- MisalignedM  output  1  misaligned access this cycle; combinational
- mem_req  output  1  request valid
- mem_we  output  1  1 = write
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated write data
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read word

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE.** An access is valid when (MemReadM | MemWriteM), Funct3M is legal and the address is aligned.
  - Valid access: register addr, we, be, wdata and Funct3M; go to REQ.
  - Otherwise stay in IDLE.
- **REQ.**
  - mem_req = 1 with all registered fields held stable.
  - On mem_gnt: a store goes to DONE; a load goes to WAIT.
- **WAIT.**
  - On mem_rvalid: capture the extracted and extended byte/half/word into ReadDataM; go to DONE.
- **DONE.**
  - One cycle with Stall = 0, so the held instruction advances.
  - No new access is evaluated in DONE; the next state is always IDLE.
- Stall = (state==IDLE & valid access) | state==REQ | state==WAIT.
- Alignment rules:
  - Halfword access requires addr[0] = 0.
  - Word access requires addr[1:0] = 00.
  - Bytes are always aligned.
- Misaligned access:
  - MisalignedM = 1 in IDLE for as long as the inputs present it.
  - No request is issued, Stall = 0, ReadDataM is unchanged.
- Illegal Funct3M: no request, no stall, MisalignedM = 0.
- Byte enables:
  - SB: mem_be = 4'b0001 << addr[1:0].
  - SH: mem_be = 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - SW: mem_be = 1111.
  - Loads: mem_be = 1111.
- Write data: SB replicates the byte to all 4 lanes; SH replicates the half to both halves.
- Load lane is selected by the registered addr[1:0]:
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.

## Timing
- Reset values: state IDLE; mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, ReadDataM 0. MisalignedM and Stall then follow their combinational definitions.
- Reset takes effect asynchronously: mem_req drops immediately, even mid-REQ or mid-WAIT. An in-flight response arriving after reset release is ignored.
- Store with grant in its first REQ cycle: cycle 0 IDLE (Stall), cycle 1 REQ (Stall), cycle 2 DONE. That is 2 stall cycles.
- Load with gnt in its first REQ cycle and rvalid one cycle later: 3 stall cycles. ReadDataM is valid from the DONE cycle and held until the next load completes.
- Each extra cycle without gnt or rvalid adds exactly one stall cycle.
- mem_rvalid must arrive no earlier than the cycle after gnt.
- Back-to-back accesses: the second access is evaluated in the IDLE cycle following DONE. The minimum spacing between access starts is 3 cycles for stores and 4 for loads.

## Test plan
- **SW, zero-wait.** addr 0x0000_1006, data 0xDEADBEEF, gnt immediate -> no request; MisalignedM = 1, Stall = 0.
  - Repeat with addr 0x0000_1004 -> mem_addr 0x1004, mem_be 1111, mem_wdata 0xDEADBEEF, we = 1, Stall high 2 cycles.
- **SB and SH lanes.** SB at 0x..03, data 0x000000A5 -> mem_be 1000, mem_wdata 0xA5A5A5A5. SH at 0x..02, data 0x1234 -> mem_be 1100, mem_wdata 0x12341234.
- **Load extension.** mem_rdata 0x80FF7F01:
  - LB at offset 3 -> 0xFFFFFF80; LBU at offset 3 -> 0x00000080.
  - LH at offset 0 -> 0x00007F01; LHU at offset 2 -> 0x000080FF; LH at offset 2 -> 0xFFFF80FF.
- **Wait states.** gnt withheld 3 cycles, then rvalid 2 cycles after gnt -> mem_req and all fields stable throughout; Stall high for exactly 3+1+2+1 = 7 cycles; ReadDataM updates only in DONE.
- **Spurious and simultaneous inputs.** rvalid pulsed while in IDLE or REQ -> ignored. MemReadM and MemWriteM both high -> store is issued.
- **Reset mid-WAIT.** rst_n low while in WAIT -> mem_req 0, ReadDataM 0, state IDLE with no clock edge needed. A late rvalid after release is ignored.
